// File: rtl/cfg_reg_pkg.sv
// Register-file view of the TX filter configuration.
// Two filter rules, each holding an IPv4 destination address, an IPv6
// destination address and a destination L4 port. A zero field acts as a
// wildcard for that field.
package cfg_reg_pkg;

  localparam int NUM_RULES = 2;

  typedef struct packed {
    logic [31:0]  ipv4_addr;
    logic [127:0] ipv6_addr;
    logic [31:0]  port;        // only [15:0] is compared; zero means any port
  } filter_rule_t;

  typedef struct packed {
    filter_rule_t [0:NUM_RULES-1] filter_rules;
  } cfg_reg_t;

endpackage

// File: rtl/packet_pkg.sv
// Packet layout constants and shared types for the TX filter.
// Beats are big-endian: byte 0 of the frame sits in tdata[511:504].
// Header layout assumes untagged Ethernet, IPv4 without options and the
// L4 destination port two bytes into the L4 header.
package packet_pkg;

  localparam int TDATA_W = 512;
  localparam int TKEEP_W = 64;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_IPV6 = 16'h86DD;

  // bytes 12..13
  localparam int ETH_TYPE_MSB = 415;
  localparam int ETH_TYPE_LSB = 400;

  // IPv4: dst ip bytes 30..33, dst port bytes 36..37
  localparam int IPV4_DST_IP_MSB   = 271;
  localparam int IPV4_DST_IP_LSB   = 240;
  localparam int IPV4_DST_PORT_MSB = 223;
  localparam int IPV4_DST_PORT_LSB = 208;

  // IPv6: dst ip bytes 38..53, dst port bytes 56..57
  localparam int IPV6_DST_IP_MSB   = 207;
  localparam int IPV6_DST_IP_LSB   = 80;
  localparam int IPV6_DST_PORT_MSB = 63;
  localparam int IPV6_DST_PORT_LSB = 48;

  typedef struct packed {
    logic [31:0] rule0_hits;
    logic [31:0] rule1_hits;
    logic [31:0] total_packets;
    logic [31:0] dropped_packets;
  } tx_counters_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } filt_state_t;

endpackage

// File: rtl/filter_tx_match.sv
// Combinational rule evaluation on the first beat of a packet.
// Ports:
//   tdata   - first beat of the packet (big-endian)
//   cfg_reg - filter rules 0 and 1
//   match0  - rule 0 matches the packet
//   match1  - rule 1 matches the packet
// Non-IP EtherTypes never match any rule.
module filter_tx_match
  import packet_pkg::*;
  import cfg_reg_pkg::*;
(
  input  logic [TDATA_W-1:0] tdata,
  input  cfg_reg_t           cfg_reg,
  output logic               match0,
  output logic               match1
);

  logic [15:0]  eth_type;
  logic         is_ipv4;
  logic         is_ipv6;
  logic [31:0]  dst_ip4;
  logic [127:0] dst_ip6;
  logic [15:0]  dst_port;

  assign eth_type = tdata[ETH_TYPE_MSB:ETH_TYPE_LSB];
  assign is_ipv4  = (eth_type == ETHERTYPE_IPV4);
  assign is_ipv6  = (eth_type == ETHERTYPE_IPV6);
  assign dst_ip4  = tdata[IPV4_DST_IP_MSB:IPV4_DST_IP_LSB];
  assign dst_ip6  = tdata[IPV6_DST_IP_MSB:IPV6_DST_IP_LSB];
  assign dst_port = is_ipv6 ? tdata[IPV6_DST_PORT_MSB:IPV6_DST_PORT_LSB]
                            : tdata[IPV4_DST_PORT_MSB:IPV4_DST_PORT_LSB];

  // Header bytes that take no part in the decision.
  logic unused_tdata;
  assign unused_tdata = ^{tdata[511:416], tdata[399:272], tdata[239:224],
                          tdata[79:64], tdata[47:0]};

  function automatic logic rule_hit(input filter_rule_t r,
                                    input logic         v4,
                                    input logic         v6,
                                    input logic [31:0]  ip4,
                                    input logic [127:0] ip6,
                                    input logic [15:0]  port);
    logic ip_ok;
    logic port_ok;
    ip_ok   = v4 ? ((r.ipv4_addr == '0) || (r.ipv4_addr == ip4))
                 : ((r.ipv6_addr == '0) || (r.ipv6_addr == ip6));
    port_ok = (r.port == '0) || (r.port[15:0] == port);
    return (v4 || v6) && ip_ok && port_ok;
  endfunction

  assign match0 = rule_hit(cfg_reg.filter_rules[0], is_ipv4, is_ipv6,
                           dst_ip4, dst_ip6, dst_port);
  assign match1 = rule_hit(cfg_reg.filter_rules[1], is_ipv4, is_ipv6,
                           dst_ip4, dst_ip6, dst_port);

endmodule

// File: rtl/filter_tx_pipeline.sv
// TX packet filter between the QDMA stream and the adapter.
// The pass/drop decision is taken on the first beat of each packet and held
// until tlast; passed beats go through a single output register stage.
//
// Ports:
//   aclk, areset   - clock, synchronous active-high reset
//   s_axis_*       - AXI-Stream in from QDMA (512-bit data, 64-bit keep)
//   m_axis_*       - AXI-Stream out to the adapter, registered
//   cfg_reg        - two filter rules
//   tx_counters    - rule0/rule1 hits, total and dropped packet counts
//
// Build option: define FILTER_TX_COUNTERS_EN to include the packet counters;
// without it tx_counters is tied to zero.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for the first beat of a packet
// PASS    | inside a passed packet, beats forwarded to m_axis
// DROP    | inside a dropped packet, beats accepted and discarded
module filter_tx_pipeline
  import packet_pkg::*;
  import cfg_reg_pkg::*;
#(
  parameter int TUSER_W = 48
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [TDATA_W-1:0] s_axis_tdata,
  input  logic [TKEEP_W-1:0] s_axis_tkeep,
  input  logic               s_axis_tlast,
  input  logic [TUSER_W-1:0] s_axis_tuser,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [TDATA_W-1:0] m_axis_tdata,
  output logic [TKEEP_W-1:0] m_axis_tkeep,
  output logic               m_axis_tlast,
  output logic [TUSER_W-1:0] m_axis_tuser,
  input  cfg_reg_t           cfg_reg,
  output tx_counters_t       tx_counters
);

  filt_state_t state;
  logic        match0;
  logic        match1;
  logic        first_pass;
  logic        load_ok;
  logic        accept;
  logic        load_beat;

  filter_tx_match u_match (
    .tdata   (s_axis_tdata),
    .cfg_reg (cfg_reg),
    .match0  (match0),
    .match1  (match1)
  );

  assign first_pass = match0 | match1;
  assign load_ok    = !m_axis_tvalid || m_axis_tready;

  // A dropped first beat still waits for the output slot so that the
  // IDLE-state ready does not depend on the match result.
  assign s_axis_tready = areset ? 1'b0 : ((state == ST_DROP) ? 1'b1 : load_ok);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign load_beat     = accept && (((state == ST_IDLE) && first_pass) ||
                                    (state == ST_PASS));

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= ST_IDLE;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (load_beat) begin
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (accept) begin
        case (state)
          ST_IDLE: begin
            if (!s_axis_tlast) begin
              state <= first_pass ? ST_PASS : ST_DROP;
            end
          end
          ST_PASS, ST_DROP: begin
            if (s_axis_tlast) begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Payload registers carry no reset; m_axis_tvalid qualifies them.
  always_ff @(posedge aclk) begin
    if (load_beat) begin
      m_axis_tdata <= s_axis_tdata;
      m_axis_tkeep <= s_axis_tkeep;
      m_axis_tlast <= s_axis_tlast;
      m_axis_tuser <= s_axis_tuser;
    end
  end

`ifdef FILTER_TX_COUNTERS_EN
  logic [31:0] rule0_q;
  logic [31:0] rule1_q;
  logic [31:0] total_q;
  logic [31:0] dropped_q;
  logic        count_pkt;

  assign count_pkt = accept && (state == ST_IDLE);

  // Counters wrap naturally at 2^32.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rule0_q   <= '0;
      rule1_q   <= '0;
      total_q   <= '0;
      dropped_q <= '0;
    end else if (count_pkt) begin
      total_q <= total_q + 32'd1;
      if (match0) begin
        rule0_q <= rule0_q + 32'd1;
      end else if (match1) begin
        rule1_q <= rule1_q + 32'd1;
      end else begin
        dropped_q <= dropped_q + 32'd1;
      end
    end
  end

  assign tx_counters = {rule0_q, rule1_q, total_q, dropped_q};
`else
  assign tx_counters = '0;
`endif

endmodule

// File: tb/tb_filter_tx_pipeline.sv
module tb_filter_tx_pipeline;
  import packet_pkg::*;
  import cfg_reg_pkg::*;

  localparam int TUSER_W = 48;

  logic               aclk = 1'b0;
  logic               areset;
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic [511:0]       s_axis_tdata;
  logic [63:0]        s_axis_tkeep;
  logic               s_axis_tlast;
  logic [TUSER_W-1:0] s_axis_tuser;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic [511:0]       m_axis_tdata;
  logic [63:0]        m_axis_tkeep;
  logic               m_axis_tlast;
  logic [TUSER_W-1:0] m_axis_tuser;
  cfg_reg_t           cfg_reg;
  tx_counters_t       tx_counters;

  int total_checks = 0;
  int bad_checks   = 0;

  always #5 aclk = ~aclk;

  filter_tx_pipeline #(.TUSER_W(TUSER_W)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .cfg_reg       (cfg_reg),
    .tx_counters   (tx_counters)
  );

  // Output monitor: a transfer at the coming posedge is visible at the negedge.
  logic [511:0] got_data[$];
  logic         got_last[$];
  int           valid_cnt = 0;

  always @(negedge aclk) begin
    if (!areset) begin
      if (m_axis_tvalid) valid_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        got_data.push_back(m_axis_tdata);
        got_last.push_back(m_axis_tlast);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] put(input logic [511:0] d, input int b,
                                       input int n, input logic [127:0] v);
    for (int i = 0; i < n; i++) d[511-8*(b+i) -: 8] = v[8*(n-1-i) +: 8];
    return d;
  endfunction

  function automatic logic [511:0] ipv4_pkt(input logic [31:0] dip, input logic [15:0] dport);
    logic [511:0] d;
    d = {16{32'h5A5A_A5A5}};
    d = put(d, 12, 2, 128'h0800);
    d = put(d, 26, 4, 128'h0A00_0063);
    d = put(d, 30, 4, {96'h0, dip});
    d = put(d, 34, 2, 128'h3039);
    d = put(d, 36, 2, {112'h0, dport});
    return d;
  endfunction

  function automatic logic [511:0] ipv6_pkt(input logic [127:0] dip, input logic [15:0] dport);
    logic [511:0] d;
    d = {16{32'h5A5A_A5A5}};
    d = put(d, 12, 2, 128'h86DD);
    d = put(d, 22, 16, 128'hFE80_0000_0000_0000_0000_0000_0000_0063);
    d = put(d, 38, 16, dip);
    d = put(d, 54, 2, 128'hBEEF);
    d = put(d, 56, 2, {112'h0, dport});
    return d;
  endfunction

  function automatic cfg_reg_t mk_cfg(input logic [31:0] a4_0, input logic [127:0] a6_0,
                                      input logic [31:0] p_0, input logic [31:0] a4_1,
                                      input logic [127:0] a6_1, input logic [31:0] p_1);
    cfg_reg_t c;
    c.filter_rules[0].ipv4_addr = a4_0;
    c.filter_rules[0].ipv6_addr = a6_0;
    c.filter_rules[0].port      = p_0;
    c.filter_rules[1].ipv4_addr = a4_1;
    c.filter_rules[1].ipv6_addr = a6_1;
    c.filter_rules[1].port      = p_1;
    return c;
  endfunction

  // Expected counter block; all zero when the counters are not built in.
  function automatic tx_counters_t exp_cnt(input logic [31:0] r0, input logic [31:0] r1,
                                           input logic [31:0] tot, input logic [31:0] drp);
    tx_counters_t c;
`ifdef FILTER_TX_COUNTERS_EN
    c.rule0_hits      = r0;
    c.rule1_hits      = r1;
    c.total_packets   = tot;
    c.dropped_packets = drp;
`else
    c = {r0, r1, tot, drp} & 128'h0;
`endif
    return c;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l,
                           input logic [TUSER_W-1:0] u, output logic rdy_first);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    rdy_first     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (i == 0) rdy_first = s_axis_tready;
      if (s_axis_tready) begin
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    total_checks++;
    bad_checks++;
    $display("FAIL send_beat_timeout: tready stayed %0b, required 1 within 20 cycles", s_axis_tready);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_last.delete();
  endtask

  task automatic test_reset();
    areset        = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = ipv4_pkt(32'h0A00_0005, 16'd80);
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b1;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    cfg_reg       = '0;
    idle(3);
    total_checks++;
    if (m_axis_tvalid !== 1'b0) begin bad_checks++; $display("FAIL reset_m_tvalid: got %b want 0", m_axis_tvalid); end
    total_checks++;
    if (s_axis_tready !== 1'b0) begin bad_checks++; $display("FAIL reset_s_tready: got %b want 0", s_axis_tready); end
    total_checks++;
    if (tx_counters !== exp_cnt(0, 0, 0, 0)) begin bad_checks++; $display("FAIL reset_counters: got %h want 0", tx_counters); end
    s_axis_tvalid = 1'b0;
    areset        = 1'b0;
    idle(1);
    total_checks++;
    if (s_axis_tready !== 1'b1) begin bad_checks++; $display("FAIL idle_s_tready: got %b want 1", s_axis_tready); end
  endtask

  task automatic test_ipv4_single();
    logic [511:0] p;
    logic         rdy;
    clear_mon();
    cfg_reg = mk_cfg(32'h0A00_0005, 128'h0, 32'd80, 32'h0102_0304, 128'h0, 32'd99);
    p = ipv4_pkt(32'h0A00_0005, 16'd80);
    total_checks++;
    if (m_axis_tvalid !== 1'b0) begin bad_checks++; $display("FAIL v4_pre_valid: got %b want 0", m_axis_tvalid); end
    send_beat(p, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 48'hABCD_EF01_2345, rdy);
    total_checks++;
    if (m_axis_tvalid !== 1'b1) begin bad_checks++; $display("FAIL v4_latency_valid: got %b want 1", m_axis_tvalid); end
    total_checks++;
    if (m_axis_tdata !== p) begin bad_checks++; $display("FAIL v4_data: got %h want %h", m_axis_tdata, p); end
    total_checks++;
    if ({m_axis_tlast, m_axis_tkeep, m_axis_tuser} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 48'hABCD_EF01_2345}) begin
      bad_checks++; $display("FAIL v4_sideband: got %h %h %h want 1 ffffffffffffffff abcdef012345", m_axis_tlast, m_axis_tkeep, m_axis_tuser);
    end
    idle(1);
    total_checks++;
    if (m_axis_tvalid !== 1'b0) begin bad_checks++; $display("FAIL v4_post_valid: got %b want 0", m_axis_tvalid); end
    total_checks++;
    if (tx_counters !== exp_cnt(1, 0, 1, 0)) begin bad_checks++; $display("FAIL v4_counters: got %h want %h", tx_counters, exp_cnt(1, 0, 1, 0)); end
  endtask

  task automatic test_ipv6_stall();
    logic [511:0] b[3];
    logic         rdy;
    clear_mon();
    cfg_reg = mk_cfg(32'h0, 128'h0, 32'd443, 32'h0, 128'h2, 32'd7);
    b[0] = ipv6_pkt(128'h2001_0DB8_0000_0000_0000_0000_0000_0001, 16'd443);
    b[1] = {16{32'h1111_2222}};
    b[2] = {16{32'h3333_4444}};
    send_beat(b[0], '1, 1'b0, 48'h0000_0000_0010, rdy);
    send_beat(b[1], '1, 1'b0, 48'h0000_0000_0011, rdy);
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b[2];
    s_axis_tkeep  = 64'h0000_0000_FFFF_FFFF;
    s_axis_tlast  = 1'b1;
    s_axis_tuser  = 48'h0000_0000_0012;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      total_checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== {1'b1, 1'b0, 48'h0000_0000_0011, b[1]}) begin
        bad_checks++; $display("FAIL v6_stall_hold cycle %0d: got v=%b l=%b u=%h d=%h", i, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata);
      end
      total_checks++;
      if (s_axis_tready !== 1'b0) begin bad_checks++; $display("FAIL v6_stall_tready cycle %0d: got %b want 0", i, s_axis_tready); end
    end
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b1;
    send_beat(b[2], 64'h0000_0000_FFFF_FFFF, 1'b1, 48'h0000_0000_0012, rdy);
    idle(3);
    total_checks++;
    if (got_data.size() !== 3) begin bad_checks++; $display("FAIL v6_beat_count: got %0d want 3", got_data.size()); end
    for (int i = 0; i < 3 && i < got_data.size(); i++) begin
      total_checks++;
      if ({got_last[i], got_data[i]} !== {(i == 2), b[i]}) begin
        bad_checks++; $display("FAIL v6_beat%0d: got l=%b d=%h want l=%b d=%h", i, got_last[i], got_data[i], (i == 2), b[i]);
      end
    end
    total_checks++;
    if (tx_counters !== exp_cnt(2, 0, 2, 0)) begin bad_checks++; $display("FAIL v6_counters: got %h want %h", tx_counters, exp_cnt(2, 0, 2, 0)); end
  endtask

  task automatic test_drop_multi();
    int   vc0;
    logic rdy;
    cfg_reg = mk_cfg(32'h0, 128'h0, 32'd80, 32'h0, 128'h0, 32'd53);
    vc0 = valid_cnt;
    send_beat(ipv4_pkt(32'h0A01_0203, 16'd22), '1, 1'b0, 48'h1, rdy);
    for (int i = 1; i < 4; i++) begin
      send_beat({16{32'h0000_1000 + i}}, '1, (i == 3), 48'h1, rdy);
      total_checks++;
      if (rdy !== 1'b1) begin bad_checks++; $display("FAIL drop_tready beat%0d: got %b want 1", i + 1, rdy); end
    end
    idle(2);
    total_checks++;
    if (valid_cnt - vc0 !== 0) begin bad_checks++; $display("FAIL drop_no_output: got %0d valid cycles want 0", valid_cnt - vc0); end
    total_checks++;
    if (tx_counters !== exp_cnt(2, 0, 3, 1)) begin bad_checks++; $display("FAIL drop_counters: got %h want %h", tx_counters, exp_cnt(2, 0, 3, 1)); end
  endtask

  task automatic test_arp();
    int           vc0;
    logic         rdy;
    logic [511:0] p;
    clear_mon();
    cfg_reg = '0;
    vc0 = valid_cnt;
    p = put(ipv4_pkt(32'h0A00_0005, 16'd80), 12, 2, 128'h0806);
    send_beat(p, '1, 1'b1, 48'h2, rdy);
    idle(2);
    total_checks++;
    if (valid_cnt - vc0 !== 0) begin bad_checks++; $display("FAIL arp_no_output: got %0d valid cycles want 0", valid_cnt - vc0); end
    total_checks++;
    if (tx_counters !== exp_cnt(2, 0, 4, 2)) begin bad_checks++; $display("FAIL arp_counters: got %h want %h", tx_counters, exp_cnt(2, 0, 4, 2)); end
    p = ipv4_pkt(32'hC0A8_0101, 16'd5000);
    send_beat(p, '1, 1'b1, 48'h3, rdy);
    idle(2);
    total_checks++;
    if (got_data.size() !== 1) begin bad_checks++; $display("FAIL wildcard_pass: got %0d beats want 1", got_data.size()); end
    total_checks++;
    if (tx_counters !== exp_cnt(3, 0, 5, 2)) begin bad_checks++; $display("FAIL wildcard_counters: got %h want %h", tx_counters, exp_cnt(3, 0, 5, 2)); end
  endtask

  task automatic test_rules();
    logic [511:0] p[6];
    logic         rdy;
    clear_mon();
    p[0] = ipv4_pkt(32'h0A00_0001, 16'd53);
    p[1] = ipv4_pkt(32'h0A00_0001, 16'd80);
    p[2] = ipv4_pkt(32'h0A00_0006, 16'd80);
    p[3] = ipv6_pkt(128'h2001_0DB8_0000_0000_0000_0000_0000_0001, 16'd1000);
    p[4] = ipv6_pkt(128'h2001_0DB8_0000_0000_0000_0000_0000_0009, 16'd1000);
    p[5] = ipv4_pkt(32'h0A00_0001, 16'd80);

    cfg_reg = mk_cfg(32'h0, 128'h0, 32'd80, 32'h0, 128'h0, 32'd53);
    send_beat(p[0], '1, 1'b1, 48'h4, rdy);
    total_checks++;
    if (tx_counters !== exp_cnt(3, 1, 6, 2)) begin bad_checks++; $display("FAIL rule1_hit: got %h want %h", tx_counters, exp_cnt(3, 1, 6, 2)); end

    cfg_reg = mk_cfg(32'h0, 128'h0, 32'd80, 32'h0, 128'h0, 32'h0);
    send_beat(p[1], '1, 1'b1, 48'h5, rdy);
    total_checks++;
    if (tx_counters !== exp_cnt(4, 1, 7, 2)) begin bad_checks++; $display("FAIL rule0_priority: got %h want %h", tx_counters, exp_cnt(4, 1, 7, 2)); end

    cfg_reg = mk_cfg(32'h0A00_0005, 128'h0, 32'd80, 32'h0909_0909, 128'h0, 32'h0);
    send_beat(p[2], '1, 1'b1, 48'h6, rdy);
    total_checks++;
    if (tx_counters !== exp_cnt(4, 1, 8, 3)) begin bad_checks++; $display("FAIL v4_ip_miss: got %h want %h", tx_counters, exp_cnt(4, 1, 8, 3)); end

    cfg_reg = mk_cfg(32'h0, 128'h2001_0DB8_0000_0000_0000_0000_0000_0001, 32'h0, 32'h0, 128'h2, 32'd7);
    send_beat(p[3], '1, 1'b1, 48'h7, rdy);
    total_checks++;
    if (tx_counters !== exp_cnt(5, 1, 9, 3)) begin bad_checks++; $display("FAIL v6_ip_hit: got %h want %h", tx_counters, exp_cnt(5, 1, 9, 3)); end
    send_beat(p[4], '1, 1'b1, 48'h8, rdy);
    total_checks++;
    if (tx_counters !== exp_cnt(5, 1, 10, 4)) begin bad_checks++; $display("FAIL v6_ip_miss: got %h want %h", tx_counters, exp_cnt(5, 1, 10, 4)); end

    cfg_reg = mk_cfg(32'h0, 128'h0, 32'h0001_0050, 32'h0909_0909, 128'h0, 32'h0);
    send_beat(p[5], '1, 1'b1, 48'h9, rdy);
    total_checks++;
    if (tx_counters !== exp_cnt(6, 1, 11, 4)) begin bad_checks++; $display("FAIL port_low16: got %h want %h", tx_counters, exp_cnt(6, 1, 11, 4)); end

    idle(2);
    total_checks++;
    if (got_data.size() !== 4) begin bad_checks++; $display("FAIL rules_beat_count: got %0d want 4", got_data.size()); end
    if (got_data.size() == 4) begin
      total_checks++;
      if ({got_data[0], got_data[1], got_data[2], got_data[3]} !== {p[0], p[1], p[3], p[5]}) begin
        bad_checks++; $display("FAIL rules_order: passed packets differ from p0,p1,p3,p5");
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] p0;
    logic [511:0] p1;
    logic         rdy;
    clear_mon();
    cfg_reg = mk_cfg(32'h0, 128'h0, 32'd80, 32'h0, 128'h0, 32'd1);
    p0 = ipv4_pkt(32'h0A00_0007, 16'd80);
    p1 = {16{32'hDEAD_BEEF}};
    send_beat(p0, '1, 1'b0, 48'hA, rdy);
    cfg_reg.filter_rules[0].port = 32'd81;
    send_beat(p1, '1, 1'b1, 48'hB, rdy);
    send_beat(p0, '1, 1'b1, 48'hC, rdy);
    idle(2);
    total_checks++;
    if (got_data.size() !== 2) begin bad_checks++; $display("FAIL midchange_count: got %0d want 2", got_data.size()); end
    if (got_data.size() == 2) begin
      total_checks++;
      if ({got_data[0], got_last[0], got_data[1], got_last[1]} !== {p0, 1'b0, p1, 1'b1}) begin
        bad_checks++; $display("FAIL midchange_beats: got %h l=%b / %h l=%b", got_data[0], got_last[0], got_data[1], got_last[1]);
      end
    end
    total_checks++;
    if (tx_counters !== exp_cnt(7, 1, 13, 5)) begin bad_checks++; $display("FAIL midchange_counters: got %h want %h", tx_counters, exp_cnt(7, 1, 13, 5)); end
  endtask

  task automatic test_wrap();
    logic rdy;
    cfg_reg = mk_cfg(32'h0, 128'h0, 32'd81, 32'h0, 128'h0, 32'd1);
`ifdef FILTER_TX_COUNTERS_EN
    force dut.total_q = 32'hFFFF_FFFF;
    @(negedge aclk);
    release dut.total_q;
    @(posedge aclk);
    #1;
`endif
    send_beat(ipv4_pkt(32'h0A00_0007, 16'd81), '1, 1'b1, 48'hD, rdy);
    total_checks++;
    if (tx_counters.total_packets !== 32'h0) begin bad_checks++; $display("FAIL total_wrap: got %h want 00000000", tx_counters.total_packets); end
    total_checks++;
    if (tx_counters.rule0_hits !== exp_cnt(8, 0, 0, 0).rule0_hits) begin
      bad_checks++; $display("FAIL wrap_rule0: got %h want %h", tx_counters.rule0_hits, exp_cnt(8, 0, 0, 0).rule0_hits);
    end
  endtask

  task automatic test_reset_mid();
    logic         rdy;
    int           vc0;
    logic [511:0] q1;
    idle(2);
    cfg_reg = mk_cfg(32'h0, 128'h0, 32'd80, 32'h0, 128'h0, 32'd99);
    send_beat(ipv4_pkt(32'h0A00_0008, 16'd80), '1, 1'b0, 48'hE, rdy);
    send_beat({16{32'h7777_0001}}, '1, 1'b0, 48'hE, rdy);
    areset = 1'b1;
    idle(1);
    total_checks++;
    if ({m_axis_tvalid, s_axis_tready} !== 2'b00) begin bad_checks++; $display("FAIL midreset_handshake: got v=%b r=%b want 0 0", m_axis_tvalid, s_axis_tready); end
    total_checks++;
    if (tx_counters !== exp_cnt(0, 0, 0, 0)) begin bad_checks++; $display("FAIL midreset_counters: got %h want 0", tx_counters); end
    idle(1);
    areset = 1'b0;
    cfg_reg = mk_cfg(32'h0, 128'h0, 32'd22, 32'h0, 128'h0, 32'd99);
    clear_mon();
    vc0 = valid_cnt;
    send_beat(ipv4_pkt(32'h0A00_0008, 16'd23), '1, 1'b1, 48'hF, rdy);
    idle(2);
    total_checks++;
    if (valid_cnt - vc0 !== 0) begin bad_checks++; $display("FAIL postreset_drop: got %0d valid cycles want 0", valid_cnt - vc0); end
    total_checks++;
    if (tx_counters !== exp_cnt(0, 0, 1, 1)) begin bad_checks++; $display("FAIL postreset_drop_cnt: got %h want %h", tx_counters, exp_cnt(0, 0, 1, 1)); end
    q1 = ipv4_pkt(32'h0A00_0008, 16'd22);
    send_beat(q1, '1, 1'b1, 48'h10, rdy);
    idle(2);
    total_checks++;
    if (got_data.size() !== 1) begin bad_checks++; $display("FAIL postreset_pass_count: got %0d want 1", got_data.size()); end
    if (got_data.size() == 1) begin
      total_checks++;
      if (got_data[0] !== q1) begin bad_checks++; $display("FAIL postreset_pass_data: got %h want %h", got_data[0], q1); end
    end
    total_checks++;
    if (tx_counters !== exp_cnt(1, 0, 2, 1)) begin bad_checks++; $display("FAIL postreset_pass_cnt: got %h want %h", tx_counters, exp_cnt(1, 0, 2, 1)); end
  endtask

  initial begin
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    cfg_reg       = '0;
    test_reset();
    test_ipv4_single();
    test_ipv6_stall();
    test_drop_multi();
    test_arp();
    test_rules();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/filter_tx_pipeline.md
FILTER_TX_PIPELINE -- requirements
Module: filter_tx_pipeline

Interface
REQ-001 Parameter TUSER_W, default 48, sets the sideband width carried unchanged on tuser.
REQ-002 Port aclk, input, 1, is the single clock; all logic SHALL be synchronous to its rising edge.
REQ-003 Port areset, input, 1, is the reset: synchronous, active-high.
REQ-004 Port s_axis_tvalid/tdata/tkeep/tlast/tuser, input, 1/512/64/1/TUSER_W, is the slave AXI-Stream from QDMA.
REQ-005 Port s_axis_tready, output, 1, is the slave-side backpressure.
REQ-006 Port m_axis_tvalid/tdata/tkeep/tlast/tuser, output, 1/512/64/1/TUSER_W, is the master AXI-Stream to the adapter.
REQ-007 Port m_axis_tready, input, 1, is the master-side backpressure.
REQ-008 Port cfg_reg, input, cfg_reg_t, supplies filter_rules[0:1] (ipv4_addr, ipv6_addr, port).
REQ-009 Port tx_counters, output, tx_counters_t, carries rule0_hits, rule1_hits, total_packets and dropped_packets, each 32 bits.

Function
REQ-010 The block SHALL decide pass/drop per packet from the first beat only (big-endian, no VLAN), and SHALL hold that decision for every beat through tlast.
REQ-011 Rule n SHALL match only when all of the following hold: EtherType is IPv4 or IPv6; (rule ipv4_addr/ipv6_addr == 0 or equals the packet DESTINATION IP); (rule port == 0 or port[15:0] equals the DESTINATION L4 port).
REQ-012 A packet SHALL pass if rule0 or rule1 matches; rule0 has priority when both match; non-IP EtherTypes SHALL be dropped.
REQ-013 The FSM SHALL have three states: IDLE (awaiting first beat), PASS and DROP.
REQ-014 From IDLE, an accepted first beat with tlast=0 SHALL go to PASS or DROP per the decision; an accepted first beat with tlast=1 SHALL stay in IDLE.
REQ-015 PASS and DROP SHALL return to IDLE on the accepted beat with tlast=1.
REQ-016 Output SHALL be a single register stage: a passed beat appears on m_axis exactly 1 cycle after acceptance.
REQ-017 In IDLE and PASS, s_axis_tready SHALL equal !m_axis_tvalid || m_axis_tready.
REQ-018 In DROP, s_axis_tready SHALL be 1 and beats SHALL be discarded; a dropped first beat SHALL be accepted under the REQ-017 rule and not loaded.
REQ-019 m_axis data/keep/last/user SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-020 Counters SHALL update on first-beat acceptance only: total +1, then exactly one of rule0_hits / rule1_hits / dropped_packets +1.
REQ-021 Counters SHALL wrap 0xFFFF_FFFF -> 0 without saturation.
REQ-022 Rule changes mid-packet SHALL affect only subsequent packets.

Reset
REQ-023 While areset=1: m_axis_tvalid=0, s_axis_tready=0, FSM=IDLE and all counters=0; data registers need not reset.
REQ-024 Reset asserted mid-packet SHALL abandon the packet; the first beat accepted after reset is treated as a new packet's first beat (upstream is reset together).

Configuration
REQ-025 With FILTER_TX_COUNTERS_EN defined, the counters SHALL operate per REQ-020/021; without it, no counter flops exist and tx_counters SHALL be tied to 0.

Structure
REQ-026 tx_counters_t and the destination-field offset constants (IPV4/IPV6 DST IP and DST PORT MSB/LSB) SHALL live in packet_pkg; cfg_reg_t remains in cfg_reg_pkg.
REQ-027 Rule evaluation SHALL be a sub-module filter_tx_match (combinational: first-beat tdata + rules -> match0, match1), instantiated once.

Verification
REQ-028 Single-beat IPv4 packet, dst 10.0.0.5:80, rule0 = {10.0.0.5, port 80} -> output 1 cycle later; rule0_hits=1, total=1.
REQ-029 3-beat IPv6 packet, dst port 443, rule0 = {ipv6 0, port 443} -> 3 beats out in order; m_axis_tready=0 for 4 cycles mid-packet leaves data stable.
REQ-030 4-beat IPv4 packet, dst port 22, rules = {port 80}, {port 53} -> no m_axis_tvalid; s_axis_tready=1 for beats 2-4; dropped=1.
REQ-031 ARP (0x0806) single beat with all-zero rules -> dropped; dropped_packets=1.
REQ-032 total_packets preloaded via force to 0xFFFF_FFFF, then 1 packet -> reads 0.
REQ-033 areset pulsed after beat 2 of a 5-beat packet, then a new packet -> counters=0 and the new packet is filtered on its own first beat.
